// File: rtl/monitor_pkg.sv
// rtl/monitor_pkg.sv - shared FSM states, default constants and pending-step helpers for monitor_word_fetch
package monitor_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_REQ  = 2'd2
  } state_e;

  // Pending/net step in two's complement: -1, 0, +1.
  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_INC  = 2'b01,
    STEP_DEC  = 2'b11
  } step_e;

  localparam int unsigned ADDR_STEP_DEF       = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned REFRESH_CYCLES_DEF  = 5000000;

  function automatic step_e step_of(input logic inc, input logic dec);
    if (inc && !dec) return STEP_INC;
    if (dec && !inc) return STEP_DEC;
    return STEP_NONE;
  endfunction

  function automatic step_e step_sat(input step_e pend, input step_e add);
    if (add == STEP_NONE) return pend;
    if (pend == STEP_NONE) return add;
    if (pend == add) return pend;
    return STEP_NONE;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - 2-FF synchronizer, stable-level debounce and press pulse for one active-low button
module button_conditioner
  import monitor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync2_q, level_q, press_q;
  logic [CNT_W-1:0] cnt_q;

  // level_q is the debounced active-low level; the counter tracks consecutive samples that disagree with it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press_q <= level_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/monitor_word_fetch.sv
// rtl/monitor_word_fetch.sv - button-driven monitor address, word fetch FSM and halfword select
// Optional periodic re-read of the current address: MONITOR_AUTO_REFRESH_EN.
module monitor_word_fetch
  import monitor_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned ADDR_STEP       = ADDR_STEP_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REFRESH_CYCLES  = REFRESH_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_inc_n,
  input  logic              btn_dec_n,
  input  logic              btn_hl_n,
  output logic [ADDR_W-1:0] mon_addr,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic [31:0]       rd_data,
  output logic [31:0]       word,
  output logic              hl_sel,
  output logic              busy
);

  logic inc_p, dec_p, hl_p, refresh_tick;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
    .clk(clk), .reset_n(reset_n), .btn_n_i(btn_inc_n), .press_o(inc_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dec (
    .clk(clk), .reset_n(reset_n), .btn_n_i(btn_dec_n), .press_o(dec_p));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_hl (
    .clk(clk), .reset_n(reset_n), .btn_n_i(btn_hl_n), .press_o(hl_p));

`ifdef MONITOR_AUTO_REFRESH_EN
  localparam int unsigned REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  logic [REF_W-1:0] refresh_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || refresh_tick) refresh_cnt_q <= '0;
    else                          refresh_cnt_q <= refresh_cnt_q + 1'b1;
  end

  assign refresh_tick = (refresh_cnt_q == REF_W'(REFRESH_CYCLES - 1));
`else
  assign refresh_tick = (REFRESH_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

  state_e            state_q;
  step_e             pend_q, pend_d, pend_idle_d, net_step, step_sel;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q;
  logic              hl_q, rd_req_q, busy_q, go_d;

  // A recorded step wins in IDLE; a press landing in that same cycle becomes the next pending step.
  always_comb begin
    net_step    = step_of(inc_p, dec_p);
    pend_d      = step_sat(pend_q, net_step);
    step_sel    = (pend_q != STEP_NONE) ? pend_q : net_step;
    pend_idle_d = (pend_q != STEP_NONE) ? net_step : STEP_NONE;
    addr_d      = addr_q;
    if (step_sel == STEP_INC)      addr_d = addr_q + ADDR_W'(ADDR_STEP);
    else if (step_sel == STEP_DEC) addr_d = addr_q - ADDR_W'(ADDR_STEP);
    go_d        = (step_sel != STEP_NONE) || refresh_tick;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      pend_q   <= STEP_NONE;
      addr_q   <= '0;
      word_q   <= '0;
      hl_q     <= 1'b0;
      rd_req_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (hl_p) hl_q <= ~hl_q;
      unique case (state_q)
        ST_INIT: begin
          state_q  <= ST_REQ;
          rd_req_q <= 1'b1;
          busy_q   <= 1'b1;
        end
        ST_IDLE: begin
          if (go_d) begin
            addr_q   <= addr_d;
            pend_q   <= pend_idle_d;
            state_q  <= ST_REQ;
            rd_req_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          pend_q <= pend_d;
          if (rd_ack) begin
            word_q   <= rd_data;
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign mon_addr = addr_q;
  assign word     = word_q;
  assign hl_sel   = hl_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_monitor_word_fetch.sv
// tb/tb_monitor_word_fetch.sv - self-checking bench for monitor_word_fetch with a reactive monitor-port model
module tb_monitor_word_fetch;

  localparam int DEB = 4;
  localparam int REF = 64;
  localparam int B_INC = 0;
  localparam int B_DEC = 1;
  localparam int B_HL  = 2;

  logic        clk = 1'b0;
  logic        reset_n, btn_inc_n, btn_dec_n, btn_hl_n;
  logic        rd_req, rd_ack, hl_sel, busy;
  logic [31:0] mon_addr, rd_data, word;

  logic        model_ack = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] model_data = '0;
  logic [31:0] force_data = '0;
  int          ack_wait = 1;
  int          age = 0;
  int          reads = 0;
  logic [31:0] read_log[$];
  bit          data_cafe = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_addr;

  always #5 clk = ~clk;

  assign rd_ack  = model_ack | force_ack;
  assign rd_data = force_ack ? force_data : model_data;

  monitor_word_fetch #(
    .ADDR_W(32), .ADDR_STEP(4), .DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_inc_n(btn_inc_n), .btn_dec_n(btn_dec_n), .btn_hl_n(btn_hl_n),
    .mon_addr(mon_addr), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .word(word), .hl_sel(hl_sel), .busy(busy)
  );

  // Monitor port: acks after rd_req has been seen for ack_wait+1 cycles; data = addr ^ A5A5_0000.
  always @(negedge clk) begin
    if (!reset_n || model_ack || !rd_req) begin
      model_ack <= 1'b0;
      age       <= 0;
    end else if (age >= ack_wait) begin
      model_ack  <= 1'b1;
      model_data <= data_cafe ? 32'hCAFE_0000 : (mon_addr ^ 32'hA5A5_0000);
      reads      <= reads + 1;
      read_log.push_back(mon_addr);
    end else begin
      age <= age + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_btn(input int which, input logic lvl);
    case (which)
      B_INC:   btn_inc_n = lvl;
      B_DEC:   btn_dec_n = lvl;
      default: btn_hl_n  = lvl;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    drive_btn(which, 1'b0);
    cycles(hold);
    drive_btn(which, 1'b1);
    cycles(10);
  endtask

  task automatic wait_reads(input int n, input string tag);
    int t = 0;
    while (reads < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(reads >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int op;
    reset_n   = 1'b0;
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    btn_hl_n  = 1'b1;
    exp_addr  = '0;
    cycles(5);
    check("rst_addr", mon_addr, 32'h0);
    check("rst_word", word, 32'h0);
    check("rst_hl", 32'(hl_sel), 32'd0);
    check("rst_req", 32'(rd_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    reset_n = 1'b1;
    wait_reads(1, "init_read");
    wait_idle("init_idle");
    check("init_read_addr", read_log[0], 32'h0);
    check("init_word", word, 32'hA5A5_0000);
    check("init_hl", 32'(hl_sel), 32'd0);

    // Short glitches must not register; a solid hold gives exactly one step.
    n = reads;
    btn_inc_n = 1'b0; cycles(2); btn_inc_n = 1'b1; cycles(3);
    btn_inc_n = 1'b0; cycles(2); btn_inc_n = 1'b1; cycles(8);
    check("glitch_addr", mon_addr, 32'h0);
    press(B_INC, 10);
    exp_addr = exp_addr + 32'd4;
    wait_reads(n + 1, "hold_read");
    wait_idle("hold_idle");
    check("hold_addr", mon_addr, exp_addr);
    check("hold_word", word, 32'hA5A5_0004);
`ifndef MONITOR_AUTO_REFRESH_EN
    check("hold_reads", 32'(reads), 32'(n + 1));
`endif

    press(B_DEC, 10);
    wait_idle("dec0_idle");
    check("dec0_addr", mon_addr, 32'h0);
    press(B_DEC, 10);
    wait_idle("decwrap_idle");
    check("decwrap_addr", mon_addr, 32'hFFFF_FFFC);
    check("decwrap_word", word, 32'h5A5A_FFFC);
    press(B_INC, 10);
    wait_idle("incwrap_idle");
    check("incwrap_addr", mon_addr, 32'h0);
    check("incwrap_word", word, 32'hA5A5_0000);

    // Press during an outstanding read at 4: read completes, then a read at 8.
    ack_wait = 40;
    n = reads;
    press(B_INC, 10);
    press(B_INC, 10);
    wait_reads(n + 1, "pend_first");
    ack_wait = 1;
    cycles(1);
`ifndef MONITOR_AUTO_REFRESH_EN
    check("pend_first_addr", read_log[n], 32'h4);
    check("pend_first_word", word, 32'hA5A5_0004);
`endif
    wait_reads(n + 2, "pend_second");
    wait_idle("pend_idle");
    check("pend_addr", mon_addr, 32'h8);
    check("pend_word", word, 32'hA5A5_0008);

    // inc and dec recorded during one read cancel out.
    ack_wait = 60;
    n = reads;
    press(B_DEC, 10);
    press(B_INC, 8);
    press(B_DEC, 8);
    ack_wait = 1;
    wait_reads(n + 1, "cancel_read");
    wait_idle("cancel_idle");
    cycles(30);
    check("cancel_addr", mon_addr, 32'h4);
    check("cancel_word", word, 32'hA5A5_0004);
`ifndef MONITOR_AUTO_REFRESH_EN
    check("cancel_reads", 32'(reads), 32'(n + 1));
`endif

    force_data = 32'h1234_5678;
    force_ack  = 1'b1;
    cycles(1);
    force_ack  = 1'b0;
    cycles(2);
    check("stray_word", word, 32'hA5A5_0004);
    check("stray_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 3; i++) begin
      press(B_HL, 8);
      check("hl_toggle", 32'(hl_sel), 32'((i + 1) % 2));
    end
    check("hl_addr", mon_addr, 32'h4);

    exp_addr = 32'h4;
    for (int i = 0; i < 10; i++) begin
      op = int'($urandom_range(0, 1));
      ack_wait = int'($urandom_range(0, 3));
      n = reads;
      press(op == 0 ? B_INC : B_DEC, int'($urandom_range(7, 12)));
      exp_addr = (op == 0) ? exp_addr + 32'd4 : exp_addr - 32'd4;
      wait_reads(n + 1, "rnd_read");
      wait_idle("rnd_idle");
      check("rnd_addr", mon_addr, exp_addr);
      check("rnd_word", word, exp_addr ^ 32'hA5A5_0000);
    end

    // Reset in the middle of a read restarts from address 0.
    ack_wait = 20;
    press(B_INC, 10);
    check("mid_req", 32'(rd_req), 32'd1);
    reset_n = 1'b0;
    cycles(1);
    check("rstreq_req", 32'(rd_req), 32'd0);
    check("rstreq_addr", mon_addr, 32'h0);
    cycles(25);
    reset_n = 1'b1;
    ack_wait = 1;
    n = reads;
    wait_reads(n + 1, "rstreq_read");
    wait_idle("rstreq_idle");
    check("rstreq_word", word, 32'hA5A5_0000);
    check("rstreq_hl", 32'(hl_sel), 32'd0);

`ifdef MONITOR_AUTO_REFRESH_EN
    begin
      int t = 0;
      data_cafe = 1'b1;
      while (word !== 32'hCAFE_0000 && t < REF + 3) begin
        @(negedge clk);
        t++;
      end
      check("refresh_word", word, 32'hCAFE_0000);
      check("refresh_addr", mon_addr, 32'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
